// File: rtl/red_pitaya_pll_supervisor.sv
// Qualifies the external reference (MMCM lock + measured frequency) and releases the
// ADC/DAC datapath reset only after both have been stable for a settle interval.
module red_pitaya_pll_supervisor #(
  parameter int unsigned GATE_CYC   = 125000,
  parameter int unsigned F_MIN      = 9900,
  parameter int unsigned F_MAX      = 10100,
  parameter int unsigned SETTLE_CYC = 1024,
  parameter int unsigned CW         = 24
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          pll_locked,
  input  logic          ext_clk_i,
  input  logic          clr_i,
  output logic          rstn_out,
  output logic [CW-1:0] freq_cnt_o,
  output logic          freq_vld_o,
  output logic          ext_ok_o,
  output logic [2:0]    state_o,
  output logic          fault_o,
  output logic [7:0]    fault_cnt_o
);

  localparam int unsigned GW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_WAIT   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  function automatic logic [CW-1:0] sat_add_cw(input logic [CW-1:0] a, input logic b);
    return (a == {CW{1'b1}}) ? a : a + CW'(b);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  function automatic logic in_range(input logic [CW-1:0] c);
    return (c >= CW'(F_MIN)) && (c <= CW'(F_MAX));
  endfunction

  logic          lock_m_q, lock_s_q;
  logic          ext_m_q, ext_s_q, ext_prev_q;
  logic          ext_rise;
  logic [GW-1:0] gate_q, gate_d;
  logic          gate_end;
  logic [CW-1:0] edge_cnt_q, edge_cnt_d, win_cnt;
  logic [CW-1:0] freq_cnt_q, freq_cnt_d;
  logic          freq_vld_q, freq_vld_d;
  logic          ext_ok_q, ext_ok_d;
  state_t        state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          rstn_out_q;
  logic          fault_q, fault_d;
  logic [7:0]    fault_cnt_q, fault_cnt_d;
  logic          fault_evt;
  logic          win_bad;

  assign ext_rise = ext_s_q & ~ext_prev_q;

  // The edge that lands on the terminal gate cycle belongs to the closing window.
  always_comb begin
    gate_end   = (gate_q == GW'(GATE_CYC - 1));
    gate_d     = gate_end ? '0 : gate_q + GW'(1);
    win_cnt    = sat_add_cw(edge_cnt_q, ext_rise);
    edge_cnt_d = gate_end ? '0 : win_cnt;
    freq_cnt_d = gate_end ? win_cnt : freq_cnt_q;
    freq_vld_d = gate_end;
    ext_ok_d   = gate_end ? in_range(win_cnt) : ext_ok_q;
  end

  assign win_bad = freq_vld_q & ~ext_ok_q;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    fault_evt = 1'b0;
    case (state_q)
      ST_RESET:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (freq_vld_q && ext_ok_q && lock_s_q) begin
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      ST_SETTLE: begin
        settle_d = settle_q + SW'(1);
        if (!lock_s_q || win_bad) state_d = ST_WAIT;
        else if (settle_d == SW'(SETTLE_CYC - 1)) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!lock_s_q || win_bad) begin
          state_d   = ST_FAULT;
          fault_evt = 1'b1;
        end
      end
      ST_FAULT:  state_d = ST_WAIT;
      default:   state_d = ST_RESET;
    endcase
  end

  // A fault arriving together with a clear must survive as a fresh first fault.
  always_comb begin
    fault_d     = fault_q;
    fault_cnt_d = fault_cnt_q;
    if (fault_evt) begin
      fault_d     = 1'b1;
      fault_cnt_d = clr_i ? 8'd1 : sat_inc8(fault_cnt_q);
    end else if (clr_i) begin
      fault_d     = 1'b0;
      fault_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_m_q    <= 1'b0;
      lock_s_q    <= 1'b0;
      ext_m_q     <= 1'b0;
      ext_s_q     <= 1'b0;
      ext_prev_q  <= 1'b0;
      gate_q      <= '0;
      edge_cnt_q  <= '0;
      freq_cnt_q  <= '0;
      freq_vld_q  <= 1'b0;
      ext_ok_q    <= 1'b0;
      state_q     <= ST_RESET;
      settle_q    <= '0;
      rstn_out_q  <= 1'b0;
      fault_q     <= 1'b0;
      fault_cnt_q <= '0;
    end else begin
      lock_m_q    <= pll_locked;
      lock_s_q    <= lock_m_q;
      ext_m_q     <= ext_clk_i;
      ext_s_q     <= ext_m_q;
      ext_prev_q  <= ext_s_q;
      gate_q      <= gate_d;
      edge_cnt_q  <= edge_cnt_d;
      freq_cnt_q  <= freq_cnt_d;
      freq_vld_q  <= freq_vld_d;
      ext_ok_q    <= ext_ok_d;
      state_q     <= state_d;
      settle_q    <= settle_d;
      rstn_out_q  <= (state_q == ST_RUN);
      fault_q     <= fault_d;
      fault_cnt_q <= fault_cnt_d;
    end
  end

  assign rstn_out    = rstn_out_q;
  assign freq_cnt_o  = freq_cnt_q;
  assign freq_vld_o  = freq_vld_q;
  assign ext_ok_o    = ext_ok_q;
  assign state_o     = state_q;
  assign fault_o     = fault_q;
  assign fault_cnt_o = fault_cnt_q;

endmodule

// File: tb/tb_red_pitaya_pll_supervisor.sv
// Bench for red_pitaya_pll_supervisor: table of window scenarios, directed corner
// sequences and randomized traffic, all checked every cycle against a reference model.
module tb_red_pitaya_pll_supervisor;

  localparam int GATE   = 1200;
  localparam int FMIN   = 95;
  localparam int FMAX   = 105;
  localparam int SETTLE = 16;
  localparam int CW     = 24;

  localparam int S_RESET  = 0;
  localparam int S_WAIT   = 1;
  localparam int S_SETTLE = 2;
  localparam int S_RUN    = 3;
  localparam int S_FAULT  = 4;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          pll_locked = 1'b0;
  logic          ext_clk_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          rstn_out;
  logic [CW-1:0] freq_cnt_o;
  logic          freq_vld_o;
  logic          ext_ok_o;
  logic [2:0]    state_o;
  logic          fault_o;
  logic [7:0]    fault_cnt_o;

  red_pitaya_pll_supervisor #(
    .GATE_CYC(GATE), .F_MIN(FMIN), .F_MAX(FMAX), .SETTLE_CYC(SETTLE), .CW(CW)
  ) dut (
    .clk(clk), .rstn(rstn), .pll_locked(pll_locked), .ext_clk_i(ext_clk_i),
    .clr_i(clr_i), .rstn_out(rstn_out), .freq_cnt_o(freq_cnt_o),
    .freq_vld_o(freq_vld_o), .ext_ok_o(ext_ok_o), .state_o(state_o),
    .fault_o(fault_o), .fault_cnt_o(fault_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // External reference: exactly gen_n rising edges per GATE cycles, phase restarts with reset.
  int gen_n = 100;
  int gen_t = 0;
  int gen_flip_pct = 0;

  // Reference model state
  bit ext_h[$];
  bit lock_h[$];
  int m_c, m_acc, m_state, m_enter, m_freq, m_fcnt;
  bit m_rstn_out, m_vld, m_ok, m_fault;

  typedef struct {
    int n;
    bit lock;
    int exp_freq;
    bit exp_ok;
    int exp_state;
  } vec_t;
  vec_t tbl[7];

  function automatic bit pattern(int t, int n);
    return ((t * n) % GATE) < (GATE / 2);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ext_h = '{0, 0, 0, 0};
    lock_h = '{0, 0, 0, 0};
    m_c = 0; m_acc = 0; m_state = S_RESET; m_enter = 0; m_freq = 0; m_fcnt = 0;
    m_rstn_out = 0; m_vld = 0; m_ok = 0; m_fault = 0;
  endtask

  task automatic model_step();
    bit rise, lock_s, bad, fevt;
    int old_state;
    if (!rstn) begin
      model_reset();
      return;
    end
    ext_h.push_front(ext_clk_i);
    void'(ext_h.pop_back());
    lock_h.push_front(pll_locked);
    void'(lock_h.pop_back());
    // an edge sampled at edge m-3/m-2 is counted at edge m; lock is seen 2 edges late
    rise = ext_h[2] && !ext_h[3];
    lock_s = lock_h[2];
    bad = m_vld && !m_ok;
    old_state = m_state;
    fevt = 0;
    m_c++;
    case (old_state)
      S_RESET: m_state = S_WAIT;
      S_WAIT: if (m_vld && m_ok && lock_s) begin m_state = S_SETTLE; m_enter = m_c; end
      S_SETTLE: begin
        if (!lock_s || bad) m_state = S_WAIT;
        else if (m_c - m_enter == SETTLE - 1) m_state = S_RUN;
      end
      S_RUN: if (!lock_s || bad) begin m_state = S_FAULT; fevt = 1; end
      S_FAULT: m_state = S_WAIT;
      default: m_state = S_RESET;
    endcase
    m_rstn_out = (old_state == S_RUN);
    if (rise) m_acc++;
    if (m_c % GATE == 0) begin
      m_freq = m_acc;
      m_vld = 1;
      m_ok = (m_acc >= FMIN) && (m_acc <= FMAX);
      m_acc = 0;
    end else begin
      m_vld = 0;
    end
    if (fevt) begin
      m_fault = 1;
      m_fcnt = clr_i ? 1 : ((m_fcnt < 255) ? m_fcnt + 1 : 255);
    end else if (clr_i) begin
      m_fault = 0;
      m_fcnt = 0;
    end
  endtask

  task automatic cyc();
    ext_clk_i = pattern(gen_t, gen_n) ^ ($urandom_range(0, 99) < gen_flip_pct);
    @(posedge clk);
    model_step();
    gen_t = rstn ? gen_t + 1 : 0;
    @(negedge clk);
    check("model", {rstn_out, freq_vld_o, ext_ok_o, state_o, fault_o, fault_cnt_o, freq_cnt_o},
          {m_rstn_out, m_vld, m_ok, 3'(m_state), m_fault, 8'(m_fcnt), 24'(m_freq)});
    clr_i = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rstn = 1'b0;
    repeat (n) cyc();
    rstn = 1'b1;
  endtask

  task automatic wait_vld(output int k, input int limit);
    k = 0;
    while (k < limit) begin
      cyc();
      k++;
      if (freq_vld_o) break;
    end
    check("vld_seen", freq_vld_o, 1);
  endtask

  task automatic wait_rstn_out(input logic val, input int limit, output int k);
    k = 0;
    while (k < limit && rstn_out !== val) begin
      cyc();
      k++;
    end
    check("rstn_out_reached", rstn_out, val);
  endtask

  task automatic recover_to_run();
    int k;
    wait_vld(k, GATE + 10);
    wait_rstn_out(1'b1, 40, k);
  endtask

  task automatic lock_loss(input bit collide, input int exp_cnt);
    int k;
    int st3;
    pll_locked = 1'b0;
    k = 0;
    st3 = -1;
    while (k < 10 && rstn_out) begin
      if (collide && k == 2) clr_i = 1'b1;
      cyc();
      k++;
      if (k == 3) st3 = state_o;
    end
    check("lockloss_latency", k, 4);
    check("lockloss_fault_state", st3, S_FAULT);
    check("lockloss_wait_state", state_o, S_WAIT);
    check("lockloss_fault_flag", fault_o, 1);
    check("lockloss_fault_cnt", fault_cnt_o, exp_cnt);
    pll_locked = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int hi_cnt;
    int drop_left;

    tbl[0] = '{100, 1'b1, 100, 1'b1, S_SETTLE};
    tbl[1] = '{120, 1'b1, 120, 1'b0, S_WAIT};
    tbl[2] = '{95,  1'b1, 95,  1'b1, S_SETTLE};
    tbl[3] = '{105, 1'b1, 105, 1'b1, S_SETTLE};
    tbl[4] = '{94,  1'b1, 94,  1'b0, S_WAIT};
    tbl[5] = '{106, 1'b1, 106, 1'b0, S_WAIT};
    tbl[6] = '{100, 1'b0, 100, 1'b1, S_WAIT};

    model_reset();
    rstn = 1'b0;
    repeat (3) cyc();
    check("reset_outputs", {rstn_out, freq_vld_o, ext_ok_o, state_o, fault_o, fault_cnt_o, freq_cnt_o}, 0);

    // Window scenarios: count, range verdict and FSM reaction to the first window
    for (int i = 0; i < 7; i++) begin
      pll_locked = tbl[i].lock;
      gen_n = tbl[i].n;
      apply_reset(2);
      wait_vld(k, GATE + 10);
      check("first_vld_latency", k, GATE);
      check("win_freq_cnt", freq_cnt_o, tbl[i].exp_freq);
      check("win_ext_ok", ext_ok_o, tbl[i].exp_ok);
      cyc();
      check("win_next_state", state_o, tbl[i].exp_state);
    end

    // Nominal lock to RUN
    pll_locked = 1'b1;
    gen_n = 100;
    apply_reset(2);
    wait_vld(k, GATE + 10);
    check("nominal_freq", freq_cnt_o, 100);
    cyc();
    check("nominal_settle", state_o, S_SETTLE);
    wait_rstn_out(1'b1, 40, k);
    check("release_latency", k + 1, SETTLE + 1);
    check("nominal_run", state_o, S_RUN);

    // Lock losses, then a clear colliding with a fault, then an isolated clear
    lock_loss(1'b0, 1);
    recover_to_run();
    lock_loss(1'b0, 2);
    recover_to_run();
    lock_loss(1'b1, 1);
    repeat (3) cyc();
    clr_i = 1'b1;
    cyc();
    check("clear_fault", fault_o, 0);
    check("clear_cnt", fault_cnt_o, 0);

    // Out-of-range window while running
    recover_to_run();
    gen_n = 120;
    wait_vld(k, GATE + 10);
    check("oor_ok", ext_ok_o, 0);
    gen_n = 100;
    wait_rstn_out(1'b0, 10, k);
    check("oor_latency", k, 2);
    check("oor_fault_cnt", fault_cnt_o, 1);

    // Lock glitch five cycles into SETTLE
    wait_vld(k, GATE + 10);
    cyc();
    check("glitch_settle", state_o, S_SETTLE);
    repeat (4) cyc();
    pll_locked = 1'b0;
    repeat (3) cyc();
    pll_locked = 1'b1;
    check("glitch_back_wait", state_o, S_WAIT);
    check("glitch_fault_cnt", fault_cnt_o, 1);
    wait_vld(k, GATE + 10);
    check("glitch_held_rstn", rstn_out, 0);
    cyc();
    check("glitch_resettle", state_o, S_SETTLE);

    // Reset in the middle of SETTLE
    repeat (3) cyc();
    rstn = 1'b0;
    cyc();
    check("midreset_outputs", {rstn_out, freq_vld_o, ext_ok_o, state_o, fault_o, fault_cnt_o, freq_cnt_o}, 0);
    rstn = 1'b1;
    wait_vld(k, GATE + 10);
    check("midreset_vld_latency", k, GATE);

    // Wrong frequency never releases the datapath
    gen_n = 120;
    apply_reset(2);
    hi_cnt = 0;
    for (int i = 0; i < 2 * GATE + 200; i++) begin
      cyc();
      if (rstn_out) hi_cnt++;
    end
    check("wrongf_rstn_high_cycles", hi_cnt, 0);
    check("wrongf_freq", freq_cnt_o, 120);
    check("wrongf_state", state_o, S_WAIT);

    // Randomized traffic against the model
    drop_left = 0;
    for (int seg = 0; seg < 6; seg++) begin
      gen_n = ($urandom_range(0, 1) == 0) ? $urandom_range(92, 108) : $urandom_range(60, 140);
      gen_flip_pct = ($urandom_range(0, 2) == 0) ? 1 : 0;
      for (int i = 0; i < 1500; i++) begin
        if (drop_left > 0) begin
          pll_locked = 1'b0;
          drop_left--;
        end else begin
          pll_locked = 1'b1;
          if ($urandom_range(0, 399) == 0) drop_left = $urandom_range(1, 6);
        end
        clr_i = ($urandom_range(0, 199) == 0);
        rstn = ($urandom_range(0, 2999) != 0);
        cyc();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
